uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arb_pkg.sv | 20 ++
 rtl/uart_tx_arb_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the uart_tx arbiter.
package uart_tx_arb_pkg;

  localparam int unsigned NReqDefault  = 4;
  localparam int unsigned DataWDefault = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitDone = 2'd2
  } arb_state_e;

  // Index base+off, wrapped once into [0, n); callers keep base < n and off < n.
  function automatic int unsigned rr_index(int unsigned base, int unsigned off, int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/uart_tx_arb_pick.sv
// Combinational winner selection for uart_tx_arbiter.
// Default: round-robin search starting at ptr, wrapping NREQ-1 -> 0.
// With UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr ignored.
module uart_tx_arb_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NREQ = NReqDefault
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    found
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [IdxW-1:0] base;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  assign base = ptr;
`endif

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(32'(base), unsigned'(i), NREQ)]) begin
        winner = IdxW'(rr_index(32'(base), unsigned'(i), NREQ));
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ requesters. The uart_tx itself sits beside this block.
// Optional build macro: UART_TX_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin; ports and FSM are identical in both builds.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NReqDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     arb_busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e        state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   winner;
  logic              found;
  logic              grant;
  logic [NREQ-1:0]   req_ready_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [IdxW-1:0]   grant_id_q;

  uart_tx_arb_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .found     (found)
  );

  // Requests are only looked at in IDLE while the transmitter is free.
  assign grant = (state_q == StIdle) && found && !tx_busy;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // Round-robin pointer: one past the last winner, modulo NREQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (winner == IdxW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  // Arbiter FSM with registered handshake and uart_tx drive outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      grant_id_q  <= '0;
    end else begin
      req_ready_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            tx_data_q           <= req_data[winner*DATA_W +: DATA_W];
            grant_id_q          <= winner;
            req_ready_q[winner] <= 1'b1;
            tx_start_q          <= 1'b1;
            state_q             <= StStart;
          end
        end
        StStart: begin
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, DATA_W=8); tx_busy driven by hand.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;

  int n_pass = 0;
  int n_chk  = 0;

  uart_tx_arbiter #(
    .NREQ   (4),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the grant, checks the START phase, then raises tx_busy into WAIT_DONE.
  task automatic wait_grant(input int gid, input logic [7:0] data);
    int k;
    logic [3:0] oh;
    oh = 4'b0001 << gid;
    k  = 0;
    step();
    while (!tx_start && k < 10) begin
      step();
      k++;
    end
    check("start_seen", 32'(tx_start), 32'd1);
    check("ready_pulse", 32'(req_ready), 32'(oh));
    check("tx_data", 32'(tx_data), 32'(data));
    check("grant_id", 32'(grant_id), 32'(gid));
    check("arb_busy_start", 32'(arb_busy), 32'd1);
    step();
    check("ready_one_cycle", 32'(req_ready), 32'd0);
    check("start_held", 32'(tx_start), 32'd1);
    check("data_stable", 32'(tx_data), 32'(data));
    tx_busy = 1'b1;
    step();
    check("wait_start_low", 32'(tx_start), 32'd0);
    check("wait_arb_busy", 32'(arb_busy), 32'd1);
  endtask

  // Keeps the frame busy a little, then ends it and checks the return to IDLE.
  task automatic finish_frame();
    step();
    step();
    tx_busy = 1'b0;
    step();
    check("idle_arb_busy", 32'(arb_busy), 32'd0);
    check("idle_start", 32'(tx_start), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h0;
    tx_busy   = 1'b0;

    // Reset held two cycles with every request up.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_arb_busy", 32'(arb_busy), 32'd0);
    end
    reset     = 1'b0;
    req_valid = 4'b0000;
    step();
    check("post_rst_idle", 32'(arb_busy), 32'd0);

    // Single request from 2.
    req_valid = 4'b0100;
    req_data  = 32'h00AA_0000;
    wait_grant(2, 8'hAA);
    req_valid = 4'b0000;
    finish_frame();

    // Wrap: pointer now past 2, requests 0 and 1.
    req_valid = 4'b0011;
    req_data  = 32'h0000_2120;
    wait_grant(0, 8'h20);
    finish_frame();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    wait_grant(0, 8'h20);
`else
    wait_grant(1, 8'h21);
`endif
    req_valid = 4'b0000;
    finish_frame();

    // Busy transmitter in IDLE blocks any grant.
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_no_start", 32'(tx_start), 32'd0);
      check("busy_no_ready", 32'(req_ready), 32'd0);
    end
    tx_busy = 1'b0;
    wait_grant(0, 8'h20);
    req_valid = 4'b0000;
    finish_frame();

    // Round-robin over all four from a fresh pointer.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      wait_grant(0, 8'h10);
`else
      wait_grant(i % 4, 8'(8'h10 + (i % 4)));
`endif
      finish_frame();
    end
    req_valid = 4'b0000;

    // Requests 1 and 3 held (pointer sits at 1 after granting 0).
    req_valid = 4'b1010;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    wait_grant(1, 8'h11);
    finish_frame();
    wait_grant(1, 8'h11);
`else
    wait_grant(1, 8'h11);
    finish_frame();
    wait_grant(3, 8'h13);
`endif
    req_valid = 4'b0000;
    finish_frame();

    // Reset during WAIT_DONE while the frame is still busy.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'b0100;
    wait_grant(2, 8'h12);
    req_valid = 4'b0010;
    step();
    check("ignore_req_gid", 32'(grant_id), 32'd2);
    check("ignore_req_data", 32'(tx_data), 32'h12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_idle", 32'(arb_busy), 32'd0);
    check("abort_start", 32'(tx_start), 32'd0);
    check("abort_gid", 32'(grant_id), 32'd0);
    check("abort_data", 32'(tx_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_start", 32'(tx_start), 32'd0);
      check("abort_no_ready", 32'(req_ready), 32'd0);
      check("abort_stay_idle", 32'(arb_busy), 32'd0);
    end
    tx_busy = 1'b0;
    wait_grant(1, 8'h11);
    req_valid = 4'b0000;
    finish_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
